// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port among N_PROC requesters.
// One transaction in flight; writes win over reads for the same requester.
module mem_arbiter #(
  parameter int N_PROC  = 4,
  parameter int ADDR_W  = 16,
  parameter int BLK     = 5,
  parameter int TIMEOUT = 64
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [N_PROC-1:0]         i_req_rd,
  input  logic [N_PROC-1:0]         i_req_wr,
  input  logic [N_PROC*ADDR_W-1:0]  i_addr,
  input  logic [N_PROC*3-1:0]       i_wr_size,
  input  logic [N_PROC*BLK*32-1:0]  i_wr_data,
  output logic [N_PROC-1:0]         o_grant_rd,
  output logic [N_PROC-1:0]         o_grant_wr,
  output logic [BLK*32-1:0]         o_rd_data,
  output logic                      o_mem_rd_en,
  output logic                      o_mem_wr_en,
  output logic [ADDR_W-1:0]         o_mem_addr,
  output logic [2:0]                o_mem_wr_size,
  output logic [BLK*32-1:0]         o_mem_wr_data,
  input  logic [BLK*32-1:0]         i_mem_rd_data,
  input  logic                      i_mem_rd_valid,
  output logic                      o_timeout
);

  localparam int PW = (N_PROC > 1) ? $clog2(N_PROC) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE, WR} state_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] cur;
  logic [CW-1:0] cnt;

  logic [N_PROC-1:0] req_any;
  logic [PW-1:0]     pick;
  logic [N_PROC-1:0] pick_oh;

  // First requester at or above the pointer, wrapping around.
  function automatic logic [PW-1:0] rr_pick(input logic [N_PROC-1:0] req,
                                            input logic [PW-1:0] ptr);
    logic [PW-1:0] sel;
    logic          found;
    int            idx;
    sel   = ptr;
    found = 1'b0;
    for (int i = 0; i < N_PROC; i++) begin
      idx = (int'(ptr) + i) % N_PROC;
      if (!found && req[idx]) begin
        sel   = PW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] k);
    return (int'(k) == N_PROC - 1) ? '0 : k + PW'(1);
  endfunction

  always_comb begin
    req_any = i_req_rd | i_req_wr;
    pick    = rr_pick(req_any, rr_ptr);
    pick_oh = '0;
    pick_oh[pick] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      cur           <= '0;
      cnt           <= '0;
      o_grant_rd    <= '0;
      o_grant_wr    <= '0;
      o_rd_data     <= '0;
      o_mem_rd_en   <= 1'b0;
      o_mem_wr_en   <= 1'b0;
      o_mem_addr    <= '0;
      o_mem_wr_size <= '0;
      o_mem_wr_data <= '0;
      o_timeout     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_grant_rd  <= '0;
          o_grant_wr  <= '0;
          o_mem_rd_en <= 1'b0;
          o_mem_wr_en <= 1'b0;
          if (|req_any) begin
            cur        <= pick;
            o_mem_addr <= i_addr[pick*ADDR_W +: ADDR_W];
            if (i_req_wr[pick]) begin
              o_mem_wr_en   <= 1'b1;
              o_grant_wr    <= pick_oh;
              o_mem_wr_size <= i_wr_size[pick*3 +: 3];
              o_mem_wr_data <= i_wr_data[pick*BLK*32 +: BLK*32];
              state         <= WR;
            end else begin
              o_mem_rd_en <= 1'b1;
              cnt         <= '0;
              state       <= RD_WAIT;
            end
          end
        end
        WR: begin
          o_mem_wr_en <= 1'b0;
          o_grant_wr  <= '0;
          rr_ptr      <= ptr_next(cur);
          state       <= IDLE;
        end
        RD_WAIT: begin
          o_mem_rd_en <= 1'b0;
          if (i_mem_rd_valid) begin
            o_rd_data        <= i_mem_rd_data;
            o_grant_rd       <= '0;
            o_grant_rd[cur]  <= 1'b1;
            cnt              <= '0;
            state            <= RD_DONE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            // Memory never answered: abandon the read without a grant.
            o_timeout <= 1'b1;
            cnt       <= '0;
            rr_ptr    <= ptr_next(cur);
            state     <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RD_DONE: begin
          o_grant_rd <= '0;
          rr_ptr     <= ptr_next(cur);
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
